// File: rtl/lsu_sram_responder.sv
// lsu_sram_responder: single-outstanding LSU data-memory responder with modelled access latency.
// Define SRAM_RAND_DELAY_EN to add 0..3 extra latency cycles drawn from an 8-bit LFSR.
module lsu_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    logic           wen;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [3:0]     wmask;
    logic [31:0]    cnt;
    logic [31:0]    load;
    logic [31:0]    off;
    logic           in_range;
    logic [AW-1:0]  idx;
    logic           access;
    logic           unused;
    logic [31:0]    mem [DEPTH_WORDS];

    if (LATENCY == 0) begin : g_latency_check
        $error("lsu_sram_responder: LATENCY must be at least 1");
    end

    // Offset wraps in 32 bits, so addresses below BASE_ADDR land far out of range.
    assign off       = addr - BASE_ADDR;
    assign in_range  = off < 32'(4 * DEPTH_WORDS);
    assign idx       = off[AW+1:2];
    assign access    = state == WAIT && cnt == 32'd0;
    assign req_ready = state == IDLE && !rst;
    assign unused    = &{1'b0, req_wmask[7:4]};

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    assign load = 32'(LATENCY - 1) + {30'd0, lfsr[1:0]};

    // Fibonacci LFSR (taps 8,6,5,4) advancing once per accepted request
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (req_valid && req_ready)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`else
    assign load = 32'(LATENCY - 1);
`endif

    // Byte-lane write commit on the same edge that enters RESP; rst drops it
    always_ff @(posedge clk) begin
        if (!rst && access && wen && in_range)
            for (int i = 0; i < 4; i++)
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    // Request/latency/response state machine with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wen   <= req_wen;
                    addr  <= req_addr;
                    wdata <= req_wdata;
                    wmask <= req_wmask[3:0];
                    cnt   <= load;
                    state <= WAIT;
                end
                WAIT: if (cnt == 32'd0) begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= !in_range;
                    resp_rdata <= (!wen && in_range) ? mem[idx] : 32'd0;
                end else begin
                    cnt <= cnt - 32'd1;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_sram_responder.sv
// tb_lsu_sram_responder: randomized scoreboard bench for lsu_sram_responder against a word-array model.
module tb_lsu_sram_responder;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LAT   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   bp = 0;
    bit   rnd_bp = 0;
    exp_t sb[$];
    int   lats[$];
    logic [31:0] ref_mem [DEPTH];

    lsu_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        resp_ready = bp ? 1'b0 : (rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: flat word array, byte-enable writes, range check on the wrapped offset.
    function automatic exp_t model(input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [7:0] wmask);
        exp_t e;
        logic [31:0] off;
        int unsigned w;
        off = addr - BASE;
        e.acc = 0;
        e.rdata = 32'd0;
        e.err = 1'b0;
        if (off >= 4 * DEPTH) begin
            e.err = 1'b1;
            return e;
        end
        w = off / 4;
        if (wen) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            e.rdata = ref_mem[w];
        end
        return e;
    endfunction

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] wmask, input bit keep);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (keep) begin
            e = model(wen, addr, wdata, wmask);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every presented response against the scoreboard front.
    bit prev_v = 0;
    bit hs = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
            hs = 0;
        end else begin
            if (hs) begin
                check("post_hs_req_ready", 32'(req_ready), 32'd1);
                check("post_hs_resp_valid", 32'(resp_valid), 32'd0);
            end
            hs = 0;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    if (!prev_v) begin
                        lats.push_back(cyc - sb[0].acc);
`ifdef SRAM_RAND_DELAY_EN
                        check("latency_range", 32'((cyc - sb[0].acc >= LAT) && (cyc - sb[0].acc <= LAT + 3)), 32'd1);
`else
                        check("latency", 32'(cyc - sb[0].acc), 32'(LAT));
`endif
                    end
                    check("resp_rdata", resp_rdata, sb[0].rdata);
                    check("resp_err", 32'(resp_err), 32'(sb[0].err));
                    check("busy_req_ready", 32'(req_ready), 32'd0);
                    if (resp_ready) begin
                        void'(sb.pop_front());
                        hs = 1;
                    end
                end
            end
            prev_v = resp_valid;
        end
    end

    initial begin
        logic [31:0] a;
        int r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_err", 32'(resp_err), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 1);
        do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 1);
        do_req(1'b1, 32'h8000_0010, 32'h0000_AB00, 8'h02, 1);
        do_req(1'b0, 32'h8000_0013, 32'h0, 8'h00, 1);
        do_req(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, 1);
        do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 1);

        do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 1);
        do_req(1'b0, 32'h8000_1000, 32'h0, 8'h00, 1);
        do_req(1'b1, 32'h8000_1000, 32'h1111_1111, 8'h0F, 1);
        do_req(1'b1, 32'h7FFF_FFFC, 32'h2222_2222, 8'h0F, 1);
        do_req(1'b0, 32'h8000_0FFC, 32'h0, 8'h00, 1);
        do_req(1'b0, 32'h8000_0000, 32'h0, 8'h00, 1);
        do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 1);
        drain();

        bp = 1;
        do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 1);
        repeat (LAT + 5) @(posedge clk);
        #1;
        check("hold_resp_valid", 32'(resp_valid), 32'd1);
        check("hold_req_ready", 32'(req_ready), 32'd0);
        bp = 0;
        drain();

        do_req(1'b1, 32'h8000_0010, 32'h1234_5678, 8'h0F, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("aborted_no_resp", 32'(resp_valid), 32'd0);
        do_req(1'b0, 32'h8000_0010, 32'h0, 8'h00, 1);
        drain();

        for (int k = 0; k < 16; k++) do_req(1'b1, BASE + 32'(4 * k), $urandom, 8'h0F, 1);
        rnd_bp = 1;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            a = (r == 0) ? BASE - 32'($urandom_range(1, 64)) :
                (r == 1) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255)) :
                BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            do_req(1'($urandom), a, $urandom, 8'($urandom), 1);
        end
        drain();
        rnd_bp = 0;

`ifdef SRAM_RAND_DELAY_EN
        begin
            int first[$];
            pulse_rst();
            lats.delete();
            for (int k = 0; k < 16; k++) do_req(1'b0, BASE + 32'(4 * k), 32'h0, 8'h00, 1);
            drain();
            first = lats;
            pulse_rst();
            lats.delete();
            for (int k = 0; k < 16; k++) do_req(1'b0, BASE + 32'(4 * k), 32'h0, 8'h00, 1);
            drain();
            check("rand_count", 32'(lats.size()), 32'(first.size()));
            for (int k = 0; k < 16 && k < lats.size() && k < first.size(); k++)
                check("rand_repeat", 32'(lats[k]), 32'(first[k]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
